// File: rtl/dmem_sram.sv
// dmem_sram: single-port byte-addressable data memory with a valid/ready
// request channel, a valid/ready response channel, configurable read latency
// and decode-time error reporting for bad sizes, misalignment and range.
module dmem_sram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2048,
    parameter logic [63:0] BASE   = 64'h8000_0000,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LW = $clog2(NB);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 2;
    // WAIT lasts RD_LAT-1 cycles; the counter is loaded with one less than that
    localparam logic [CW-1:0] CNT_INIT = (RD_LAT > 1) ? CW'(RD_LAT - 2) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                live_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [63:0]         offset;
    logic [63:0]         widx;
    logic [LW-1:0]       lane;
    logic [AW-1:0]       word_idx;
    logic                len_ok;
    logic                aligned;
    logic                in_range;
    logic                dec_err;
    logic                accept;
    logic [NB-1:0]       wr_strb;
    logic [DATA_W-1:0]   wdata_sh;
    logic [DATA_W-1:0]   rd_sh;
    logic [DATA_W-1:0]   rd_val;

    assign offset   = req_addr - BASE;
    assign widx     = offset >> LW;
    assign lane     = offset[LW-1:0];
    assign word_idx = widx[AW-1:0];

    assign len_ok   = (req_len == 8'd1) || (req_len == 8'd2) || (req_len == 8'd4) ||
                      ((req_len == 8'd8) && (DATA_W == 64));
    assign aligned  = (offset[3:0] & (req_len[3:0] - 4'd1)) == 4'd0;
    assign in_range = widx < 64'(DEPTH);
    assign dec_err  = !(len_ok && aligned && in_range);

    // live_q keeps req_ready low until the first clock edge after reset release
    assign req_ready = (state_q == IDLE) && live_q;
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign wdata_sh  = req_wdata << {lane, 3'b000};
    assign rd_sh     = mem_q[word_idx] >> {lane, 3'b000};

    // Byte strobe for writes and zero-extending byte mask for reads
    always_comb begin
        wr_strb = '0;
        rd_val  = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            wr_strb[b] = (b >= 32'(lane)) && (b < 32'(lane) + 32'(req_len));
            if (b < 32'(req_len)) begin
                rd_val[8*b +: 8] = rd_sh[8*b +: 8];
            end
        end
    end

    // Storage: strobed bytes commit on the accept edge; never reset
    always_ff @(posedge clk) begin
        if (accept && req_we && !dec_err) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Transaction state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic: read data and error are captured at accept and held
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d   = dec_err;
                    rdata_d = (!req_we && !dec_err) ? rd_val : '0;
                    if (dec_err || req_we || (RD_LAT <= 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_sram.sv
// tb_dmem_sram: directed-vector bench for dmem_sram (64-bit, RD_LAT = 3).
module tb_dmem_sram;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_err    = 0;

    dmem_sram #(
        .DATA_W (64),
        .DEPTH  (2048),
        .BASE   (64'h8000_0000),
        .RD_LAT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and return just after its accept edge (bounded wait)
    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] len, output logic ok);
        int n;
        ok = 1'b1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_len = len;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", 64'd0, 64'd1);
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Full transaction: latency, busy window, optional backpressure hold
    task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] len, input int hold, input logic early,
                        output logic [63:0] rd, output logic er, output int lat,
                        output logic busy_ok, output logic stable);
        logic ok;
        rd = '0; er = 1'b0; lat = 0; busy_ok = 1'b1; stable = 1'b1;
        rsp_ready = early;
        issue(we, addr, wd, len, ok);
        if (!ok) begin
            rsp_ready = 1'b0;
            return;
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (rsp_valid !== 1'b1) begin
            check("rsp_timeout", 64'd0, 64'd1);
            rsp_ready = 1'b0;
            return;
        end
        if (req_ready !== 1'b0) busy_ok = 1'b0;
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [63:0] addr, input logic [63:0] wd,
                      input logic [7:0] len, input logic exp_err);
        logic [63:0] rd; logic er; int lat; logic bo; logic st;
        xact(1'b1, addr, wd, len, 0, 1'b0, rd, er, lat, bo, st);
        check({tag, "_err"}, 64'(er), 64'(exp_err));
        check({tag, "_data"}, rd, 64'd0);
        check({tag, "_lat"}, 64'(lat), 64'd1);
    endtask

    task automatic rdc(input string tag, input logic [63:0] addr, input logic [7:0] len,
                       input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
        logic [63:0] rd; logic er; int lat; logic bo; logic st;
        xact(1'b0, addr, 64'd0, len, 0, 1'b0, rd, er, lat, bo, st);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, 64'(er), 64'(exp_err));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic        bo;
        logic        st;
        logic        ok;
        logic        never;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_len = '0; rsp_ready = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("rel_ready_pre", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_ready_post", 64'(req_ready), 64'd1);

        // Single-byte write into a zeroed word
        wr("w_zero", B, 64'd0, 8'd8, 1'b0);
        wr("w_ab", B + 64'd3, 64'hAB, 8'd1, 1'b0);
        rdc("r_ab", B, 8'd8, 64'h0000_0000_AB00_0000, 1'b0, 3);

        // Error cases: misalignment, bad size, out of range, below BASE
        wr("w_misal", B + 64'd2, 64'hFFFF_FFFF, 8'd4, 1'b1);
        rdc("r_misal", B + 64'd2, 8'd4, 64'd0, 1'b1, 1);
        rdc("r_len3", B, 8'd3, 64'd0, 1'b1, 1);
        rdc("r_len0", B, 8'd0, 64'd0, 1'b1, 1);
        rdc("r_misal8", B + 64'd4, 8'd8, 64'd0, 1'b1, 1);
        rdc("r_oob", B + 64'h4000, 8'd8, 64'd0, 1'b1, 1);
        rdc("r_below", B - 64'd8, 8'd8, 64'd0, 1'b1, 1);
        rdc("r_unch", B, 8'd8, 64'h0000_0000_AB00_0000, 1'b0, 3);

        // Last legal word
        wr("w_last", B + 64'h3FF8, 64'hA5A5_0000_1234_5678, 8'd8, 1'b0);
        rdc("r_last", B + 64'h3FFC, 8'd4, 64'h0000_0000_A5A5_0000, 1'b0, 3);

        // Back-to-back write then narrow read
        wr("w_b2b", B + 64'd16, 64'h1122_3344_5566_7788, 8'd8, 1'b0);
        rdc("r_b2b", B + 64'd22, 8'd2, 64'h1122, 1'b0, 3);
        rdc("r_b1", B + 64'd17, 8'd1, 64'h77, 1'b0, 3);
        rdc("r_w4", B + 64'd20, 8'd4, 64'h1122_3344, 1'b0, 3);

        // Partial writes; high wdata bits beyond len must be ignored
        wr("w_h2", B + 64'd18, 64'hBEEF, 8'd2, 1'b0);
        wr("w_junk", B + 64'd20, 64'hFFFF_FFFF_FFFF_CAFE, 8'd2, 1'b0);
        rdc("r_merge", B + 64'd16, 8'd8, 64'h1122_CAFE_BEEF_7788, 1'b0, 3);
        rdc("r_misal2", B + 64'd17, 8'd2, 64'd0, 1'b1, 1);

        // Backpressure: response held 5 cycles, busy throughout
        xact(1'b0, B + 64'd16, 64'd0, 8'd8, 5, 1'b0, rd, er, lat, bo, st);
        check("hold_data", rd, 64'h1122_CAFE_BEEF_7788);
        check("hold_lat", 64'(lat), 64'd3);
        check("hold_busy", 64'(bo), 64'd1);
        check("hold_stable", 64'(st), 64'd1);

        // rsp_ready high before the response exists
        xact(1'b0, B + 64'd22, 64'd0, 8'd2, 0, 1'b1, rd, er, lat, bo, st);
        check("early_data", rd, 64'h1122);
        check("early_lat", 64'(lat), 64'd3);

        // Reset while a write response is pending: write stays committed
        issue(1'b1, B + 64'h100, 64'hDEAD_BEEF_0123_4567, 8'd8, ok);
        check("rw_resp_pre", 64'(rsp_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("rw_valid_drop", 64'(rsp_valid), 64'd0);
        check("rw_ready_drop", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rw_ready_back", 64'(req_ready), 64'd1);
        check("rw_no_rsp", 64'(rsp_valid), 64'd0);

        // Reset during WAIT: response dropped
        issue(1'b0, B + 64'h100, 64'd0, 8'd8, ok);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rr_valid_drop", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        never = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) never = 1'b0;
        end
        check("rr_no_rsp", 64'(never), 64'd1);
        rdc("r_after_rst", B + 64'h100, 8'd8, 64'hDEAD_BEEF_0123_4567, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
